sdram_arbiter: RTL

- Shares the single SDRAM user port (portA/portDi/portDo, active-low read and write strobes) between two requesters.
  - The Z80 main-RAM path.
  - A DMA path used by the cassette/tape image loader to deposit bytes into Lynx RAM.
- Sits between the CPU address decode and the sdram controller.
- Sequences one fixed-length access at a time.
- Arbitrates with CPU priority plus round-robin fairness on conflict.
- Returns read data and completion strobes to each side.

---
 rtl/sdram_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter for the single SDRAM user port: the Z80 main-RAM path and the tape-loader DMA.
// Runs one fixed-length access at a time; CPU wins the first conflict, after which conflicts alternate.
module sdram_arbiter #(
    parameter int AW  = 24,
    parameter int LAT = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ready,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuDi,
    output logic [7:0]    cpuDo,
    output logic          cpuAck,
    input  logic          dmaReq,
    input  logic          dmaWe,
    input  logic [AW-1:0] dmaA,
    input  logic [7:0]    dmaDi,
    output logic [7:0]    dmaDo,
    output logic          dmaAck,
    output logic          busy,
    output logic          sdrRd,
    output logic          sdrWr,
    output logic [AW-1:0] sdrA,
    output logic [15:0]   sdrDi,
    input  logic [15:0]   sdrDo
);
    localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} own_t;

    state_t        r_state, w_state_n;
    own_t          r_owner, w_owner_n;
    own_t          r_last,  w_last_n;
    logic [CW-1:0] r_cnt,   w_cnt_n;
    logic          r_rd,    w_rd_n;
    logic          r_wr,    w_wr_n;
    logic [AW-1:0] r_a,     w_a_n;
    logic [15:0]   r_di,    w_di_n;
    logic [7:0]    r_cpuDo, w_cpuDo_n;
    logic [7:0]    r_dmaDo, w_dmaDo_n;
    logic          r_cpuAck, w_cpuAck_n;
    logic          r_dmaAck, w_dmaAck_n;
    logic          r_busy,  w_busy_n;

    logic          w_gnt_cpu, w_gnt_dma;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_a;
    logic [7:0]    w_sel_di;
    logic          w_unused;

    assign w_unused = ^sdrDo[15:8];

    // On conflict the side that was not served last goes first; lastOwner resets to DMA so CPU wins first.
    assign w_gnt_cpu = cpuReq & (~dmaReq | (r_last == OWN_DMA));
    assign w_gnt_dma = dmaReq & (~cpuReq | (r_last == OWN_CPU));

    assign w_sel_we = w_gnt_dma ? dmaWe : cpuWe;
    assign w_sel_a  = w_gnt_dma ? dmaA  : cpuA;
    assign w_sel_di = w_gnt_dma ? dmaDi : cpuDi;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_CPU;
            r_last   <= OWN_DMA;
            r_cnt    <= '0;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_a      <= '0;
            r_di     <= '0;
            r_cpuDo  <= 8'hFF;
            r_dmaDo  <= 8'hFF;
            r_cpuAck <= 1'b0;
            r_dmaAck <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_owner  <= w_owner_n;
            r_last   <= w_last_n;
            r_cnt    <= w_cnt_n;
            r_rd     <= w_rd_n;
            r_wr     <= w_wr_n;
            r_a      <= w_a_n;
            r_di     <= w_di_n;
            r_cpuDo  <= w_cpuDo_n;
            r_dmaDo  <= w_dmaDo_n;
            r_cpuAck <= w_cpuAck_n;
            r_dmaAck <= w_dmaAck_n;
            r_busy   <= w_busy_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_owner_n  = r_owner;
        w_last_n   = r_last;
        w_cnt_n    = r_cnt;
        w_rd_n     = r_rd;
        w_wr_n     = r_wr;
        w_a_n      = r_a;
        w_di_n     = r_di;
        w_cpuDo_n  = r_cpuDo;
        w_dmaDo_n  = r_dmaDo;
        w_cpuAck_n = 1'b0;
        w_dmaAck_n = 1'b0;
        w_busy_n   = r_busy;
        case (r_state)
            S_IDLE: begin
                if (ready && (w_gnt_cpu || w_gnt_dma)) begin
                    w_owner_n = w_gnt_dma ? OWN_DMA : OWN_CPU;
                    w_a_n     = w_sel_a;
                    w_di_n    = {2{w_sel_di}};
                    w_wr_n    = ~w_sel_we;
                    w_rd_n    = w_sel_we;
                    w_cnt_n   = CW'(LAT - 1);
                    w_busy_n  = 1'b1;
                    w_state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    // Read data is captured on the same edge the strobe is released.
                    if (!r_rd) begin
                        if (r_owner == OWN_DMA) w_dmaDo_n = sdrDo[7:0];
                        else                    w_cpuDo_n = sdrDo[7:0];
                    end
                    w_rd_n     = 1'b1;
                    w_wr_n     = 1'b1;
                    w_cpuAck_n = (r_owner == OWN_CPU);
                    w_dmaAck_n = (r_owner == OWN_DMA);
                    w_last_n   = r_owner;
                    w_busy_n   = 1'b0;
                    w_state_n  = S_DONE;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                // One dead cycle lets the served requester drop its level request.
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign cpuDo  = r_cpuDo;
    assign dmaDo  = r_dmaDo;
    assign cpuAck = r_cpuAck;
    assign dmaAck = r_dmaAck;
    assign busy   = r_busy;
    assign sdrRd  = r_rd;
    assign sdrWr  = r_wr;
    assign sdrA   = r_a;
    assign sdrDi  = r_di;
endmodule
